i2c_master_arbiter: RTL and testbench

Shares one I2C master engine among NREQ requesters. Round-robin arbitration picks one pending request, latches its command (7-bit address, R/W, write byte), issues it to the master with a start pulse, and waits for completion or a watchdog timeout. It then returns a one-cycle done pulse with NACK/timeout status and read data to the granted requester. It sits between the system-side requesters and the bit-level I2C master FSM.

---
 rtl/i2c_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/i2c_master_arbiter.sv | 140 ++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared constants and state encoding for controllers that front the I2C master engine.
package i2c_ctrl_pkg;
  localparam int ADDR_W          = 7;
  localparam int DATA_W          = 8;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first set req above ptr (mod NREQ).
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);
  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest candidate above ptr is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master engine among NREQ requesters with round-robin grant and a watchdog.
module i2c_master_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   nack,
  output logic                   timeout,
  output logic [DATA_W-1:0]      rdata,
  output logic                   m_start,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_rw,
  output logic [DATA_W-1:0]      m_wdata,
  output logic                   m_abort,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_nack,
  input  logic [DATA_W-1:0]      m_rdata,
  output state_t                 dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Master handshake: m_start is issued only from ISSUE with m_busy low; the
  // master answers with a single m_done pulse (m_nack/m_rdata valid with it),
  // and m_done is honoured only in WAIT.
  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, owner_idx, win_idx;
  logic [NREQ-1:0]     arb_gnt;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_rw;
  logic [DATA_W-1:0]   win_wdata;
  logic [TW-1:0]       timer;
  logic                expire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx   = '0;
    win_addr  = '0;
    win_rw    = 1'b0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx   = IW'(i);
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_rw    = req_rw[i];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Timer holds 1 in the last WAIT cycle; m_done in that same cycle takes priority.
  assign expire = (timer == TW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req) state_nxt = ST_ISSUE;
      ST_ISSUE: if (!m_busy) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (m_done || expire) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= IW'(NREQ - 1);
      owner_idx <= '0;
      gnt       <= '0;
      done      <= '0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
      rdata     <= '0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_wdata   <= '0;
      m_abort   <= 1'b0;
      timer     <= '0;
    end else begin
      state   <= state_nxt;
      m_start <= (state == ST_ISSUE) && !m_busy;
      done    <= '0;
      m_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= arb_gnt;
            owner_idx <= win_idx;
            m_addr    <= win_addr;
            m_rw      <= win_rw;
            m_wdata   <= win_wdata;
          end
        end
        ST_START: timer <= TW'(TIMEOUT);
        ST_WAIT: begin
          if (m_done) begin
            nack    <= m_nack;
            timeout <= 1'b0;
            rdata   <= (m_rw && !m_nack) ? m_rdata : '0;
            done    <= gnt;
          end else if (expire) begin
            nack    <= 1'b0;
            timeout <= 1'b1;
            rdata   <= '0;
            done    <= gnt;
            m_abort <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_RESP: begin
          gnt <= '0;
          ptr <= owner_idx;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter against a transaction-level round-robin model.
module tb_i2c_master_arbiter;
  import i2c_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 15;

  logic                   CLK = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ-1:0]        req_rw = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        gnt, done;
  logic                   nack, timeout, m_start, m_rw, m_abort;
  logic [DATA_W-1:0]      rdata, m_wdata;
  logic [ADDR_W-1:0]      m_addr;
  logic                   m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [DATA_W-1:0]      m_rdata = '0;
  state_t                 dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = NREQ - 1;

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .nack(nack), .timeout(timeout),
    .rdata(rdata), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_rw[i]                     = rw;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic randomize_cmds();
    for (int i = 0; i < NREQ; i++)
      set_cmd(i, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
  endtask

  // Entered at a negedge with the DUT in IDLE and req already driven (nonzero).
  // dly in 1..TMO: m_done seen in the dly-th WAIT cycle; dly > TMO: never answered.
  task automatic run_txn(input int dly, input bit nk, input logic [7:0] rd,
                         input int busy, input bit drop, output int w);
    logic [6:0] ea;
    logic       ew;
    logic [7:0] ed, erd;
    bit         to;
    int         last;
    w  = model_winner(req, mptr);
    ea = req_addr[w*ADDR_W +: ADDR_W];
    ew = req_rw[w];
    ed = req_wdata[w*DATA_W +: DATA_W];
    to = (dly > TMO);
    m_busy = (busy > 0);
    @(negedge CLK);
    check_eq("gnt", 32'(gnt), 32'(1) << w);
    check_eq("done_at_gnt", 32'(done), 0);
    check_eq("start_early", 32'(m_start), 0);
    m_done  = 1'($urandom_range(0, 1));
    m_nack  = 1'b1;
    m_rdata = 8'hFF;
    for (int i = 0; i < busy; i++) begin
      @(negedge CLK);
      m_done = 1'b0;
      check_eq("stall_start", 32'(m_start), 0);
    end
    m_busy = 1'b0;
    @(negedge CLK);
    m_done = 1'b0;
    check_eq("m_start", 32'(m_start), 1);
    check_eq("m_addr", 32'(m_addr), 32'(ea));
    check_eq("m_rw", 32'(m_rw), 32'(ew));
    check_eq("m_wdata", 32'(m_wdata), 32'(ed));
    if (drop) req[w] = 1'b0;
    randomize_cmds();
    m_nack  = nk;
    m_rdata = rd;
    last = to ? TMO : dly;
    for (int i = 1; i <= last; i++) begin
      @(negedge CLK);
      check_eq("done_early", 32'({m_abort, done}), 0);
      m_done = (!to && i == dly);
    end
    @(negedge CLK);
    m_done = 1'b0;
    erd = (!to && ew && !nk) ? rd : 8'h00;
    check_eq("done", 32'(done), 32'(1) << w);
    check_eq("timeout", 32'(timeout), 32'(to));
    check_eq("nack", 32'(nack), 32'(!to && nk));
    check_eq("rdata", 32'(rdata), 32'(erd));
    check_eq("m_abort", 32'(m_abort), 32'(to));
    check_eq("m_addr_held", 32'(m_addr), 32'(ea));
    @(negedge CLK);
    check_eq("idle_gnt", 32'({m_abort, done, gnt}), 0);
    check_eq("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("held_status", 32'({timeout, nack, rdata}), 32'({to, !to && nk, erd}));
    mptr = w;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge CLK);
    check_eq("rst_outs", 32'({gnt, done, nack, timeout, m_start, m_abort}), 0);
    check_eq("rst_cmd", 32'({rdata, m_addr, m_rw, m_wdata}), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Fairness: all four held for eight transactions.
    reset = 1'b0;
    randomize_cmds();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      run_txn($urandom_range(1, TMO), 1'b0, 8'h00, 0, 1'b0, w);
      check_eq("rr_order", 32'(w), 32'(i % NREQ));
      req = 4'b1111;
    end

    // Single write, then read ack / read nack.
    set_cmd(0, 7'h67, 1'b0, 8'hAA);
    req = 4'b0001;
    run_txn(12, 1'b0, 8'h33, 0, 1'b0, w);
    set_cmd(1, 7'h21, 1'b1, 8'h00);
    req = 4'b0010;
    run_txn(5, 1'b0, 8'h5C, 0, 1'b0, w);
    set_cmd(1, 7'h21, 1'b1, 8'h00);
    req = 4'b0010;
    run_txn(7, 1'b1, 8'h5C, 0, 1'b0, w);

    // Busy stall, timeout, and m_done on the expiry cycle.
    randomize_cmds();
    req = 4'b0100;
    run_txn(3, 1'b0, 8'h11, 10, 1'b0, w);
    randomize_cmds();
    req = 4'b1000;
    run_txn(TMO + 1, 1'b0, 8'h77, 0, 1'b0, w);
    randomize_cmds();
    req_rw[0] = 1'b1;
    req = 4'b0001;
    run_txn(TMO, 1'b0, 8'h9E, 0, 1'b0, w);

    // Random mix, including owners that drop req mid-transaction.
    for (int n = 0; n < 40; n++) begin
      randomize_cmds();
      req = 4'($urandom_range(1, 15));
      run_txn($urandom_range(1, TMO + 2), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0), w);
    end

    // Reset in WAIT drops the transaction silently.
    randomize_cmds();
    req = 4'b0100;
    repeat (5) @(negedge CLK);
    check_eq("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge CLK);
    check_eq("rst_wait_gnt", 32'({gnt, done, m_abort, m_start}), 0);
    check_eq("rst_wait_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    mptr  = NREQ - 1;
    randomize_cmds();
    req = 4'b0001;
    run_txn(4, 1'b0, 8'h42, 0, 1'b0, w);
    check_eq("post_rst_owner", 32'(w), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
